// File: rtl/systolic_mac_array_if.sv
// Operand, command and result bundle for systolic_mac_array.
// master = operand/command source and result sink; slave = the array.
interface systolic_mac_array_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 40,
    parameter int unsigned LW = 16
);
    logic            cmd_valid;
    logic [LW-1:0]   cmd_len;
    logic            cmd_acc;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   a_data;
    logic [N*DW-1:0] b_data;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_data;
    logic            done;

    modport master (
        output cmd_valid, cmd_len, cmd_acc, in_valid, a_data, b_data, out_ready,
        input  busy, in_ready, out_valid, out_data, done
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_acc, in_valid, a_data, b_data, out_ready,
        output busy, in_ready, out_valid, out_data, done
    );
endinterface

// File: rtl/systolic_mac_array.sv
// 1-D output-stationary systolic MAC chain: N PEs, skewed B operands, drained result stream.
// Optional macro SYSTOLIC_MAC_SAT_EN: saturating accumulation instead of modulo-2^AW wrap.
module systolic_mac_array #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 40,
    parameter int unsigned LW = 16
) (
    input logic                clk,
    input logic                reset,
    systolic_mac_array_if.slave bus
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] fl_q, fl_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          accept;
    logic          step;
    logic          clear;

    logic [AW-1:0] acc_q [N];
    logic [DW-1:0] a_q [N-1];
    logic [N-2:0]  v_q;

    logic [DW-1:0] a_in [N];
    logic [N-1:0]  v_in;
    logic [DW-1:0] b_dly [N];
    logic [AW-1:0] acc_nx [N];

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = acc_q[idx_q];
    assign bus.done      = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Sequencing: a step advances every chain/skew register and the accumulators.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    len_d   = bus.cmd_len;
                    cnt_d   = '0;
                    clear   = ~bus.cmd_acc;
                    state_d = (bus.cmd_len != '0) ? LOAD : DRAIN;
                end
            end
            LOAD: begin
                accept = bus.in_valid;
                step   = bus.in_valid;
                if (bus.in_valid) begin
                    if (cnt_q == len_q - LW'(1)) begin
                        cnt_d   = '0;
                        fl_d    = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            FLUSH: begin
                step = 1'b1;
                if (fl_q == IW'(N - 2)) begin
                    fl_d    = '0;
                    state_d = DRAIN;
                end else begin
                    fl_d = fl_q + IW'(1);
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pe
        logic signed [2*DW-1:0] prod;
        logic [AW-1:0]          addend;

        if (gi == 0) begin : g_head
            // FLUSH injects a zero, invalid beat at the chain head.
            assign a_in[0]  = (state_q == LOAD) ? bus.a_data : '0;
            assign v_in[0]  = accept;
            assign b_dly[0] = bus.b_data[0 +: DW];
        end else begin : g_tail
            logic [DW-1:0] sk_q [gi];
            logic [DW-1:0] b_new;

            assign b_new = (state_q == LOAD) ? bus.b_data[gi*DW +: DW] : '0;

            // Slice gi is delayed gi steps to meet its A beat at PE gi.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < gi; k++) sk_q[k] <= '0;
                end else if (step) begin
                    sk_q[0] <= b_new;
                    for (int k = 1; k < gi; k++) sk_q[k] <= sk_q[k-1];
                end
            end

            assign b_dly[gi] = sk_q[gi-1];
            assign a_in[gi]  = a_q[gi-1];
            assign v_in[gi]  = v_q[gi-1];
        end

        assign prod   = (2*DW)'($signed(a_in[gi])) * (2*DW)'($signed(b_dly[gi]));
        assign addend = AW'(prod);

`ifdef SYSTOLIC_MAC_SAT_EN
        logic [AW:0] sum;
        assign sum = {acc_q[gi][AW-1], acc_q[gi]} + {addend[AW-1], addend};
        assign acc_nx[gi] = (sum[AW] == sum[AW-1]) ? sum[AW-1:0] :
                            (sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
`else
        assign acc_nx[gi] = acc_q[gi] + addend;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) acc_q[i] <= '0;
            for (int i = 0; i < N - 1; i++) a_q[i] <= '0;
            v_q <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < N; i++) acc_q[i] <= '0;
            end else if (step) begin
                for (int i = 0; i < N; i++) begin
                    if (v_in[i]) acc_q[i] <= acc_nx[i];
                end
            end
            if (step) begin
                for (int i = 0; i < N - 1; i++) begin
                    a_q[i] <= a_in[i];
                    v_q[i] <= v_in[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array (N=4, DW=8, AW=20).
module tb_systolic_mac_array;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_mac_array_if #(.N(N), .DW(DW), .AW(AW), .LW(LW)) bus ();

    systolic_mac_array #(.N(N), .DW(DW), .AW(AW), .LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [AW-1:0] res [N];
    logic [AW-1:0] exp_v;
    int ndone;
    int first_ov;
    int busy_after;

    always @(posedge clk) cyc = cyc + 1;

    task automatic issue_cmd(input int len, input logic acc, output int c0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        bus.cmd_acc   = acc;
        c0 = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input int a, input int b0, input int b1, input int b2, input int b3);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checks++;
            $display("FAIL send_beat in_ready timeout: got %0b expected 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a_data   = DW'(a);
        bus.b_data   = {DW'(b3), DW'(b2), DW'(b1), DW'(b0)};
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Collects results idx start..N-1 with out_ready high, then watches done and busy.
    task automatic drain(input int start);
        int got = start;
        int w = 0;
        bit prev_done = 1'b0;
        ndone = 0;
        first_ov = -1;
        busy_after = -1;
        bus.out_ready = 1'b1;
        while (got < N && w < 200) begin
            if (bus.out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                res[got] = bus.out_data;
                got++;
            end
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            $display("FAIL drain timeout: got %0d results expected %0d", got, N);
        end
        for (int k = 0; k < 3; k++) begin
            if (prev_done) busy_after = int'(bus.busy);
            prev_done = bus.done;
            if (bus.done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b expected 0", bus.done); else passes++;
        checks++; if (bus.out_data !== '0) $display("FAIL reset out_data: got %0d expected 0", bus.out_data); else passes++;
    endtask

    task automatic test_basic;
        int c0;
        issue_cmd(1, 1'b0, c0);
        send_beat(3, 1, 2, 3, 4);
        drain(0);
        for (int i = 0; i < N; i++) begin
            exp_v = AW'(3 * (i + 1));
            checks++;
            if (res[i] !== exp_v) $display("FAIL basic res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
        checks++; if (first_ov != c0 + 1 + 1 + N - 1) $display("FAIL basic latency: got %0d expected %0d", first_ov - c0, 1 + 1 + N - 1); else passes++;
        checks++; if (ndone != 1) $display("FAIL basic done pulses: got %0d expected 1", ndone); else passes++;
        checks++; if (busy_after != 0) $display("FAIL basic busy after done: got %0d expected 0", busy_after); else passes++;
    endtask

    task automatic test_accumulate;
        int c0;
        issue_cmd(1, 1'b1, c0);
        send_beat(3, 1, 2, 3, 4);
        drain(0);
        for (int i = 0; i < N; i++) begin
            exp_v = AW'(6 * (i + 1));
            checks++;
            if (res[i] !== exp_v) $display("FAIL accumulate res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
        issue_cmd(0, 1'b1, c0);
        drain(0);
        for (int i = 0; i < N; i++) begin
            exp_v = AW'(6 * (i + 1));
            checks++;
            if (res[i] !== exp_v) $display("FAIL k0 redrain res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
        checks++; if (ndone != 1) $display("FAIL k0 done pulses: got %0d expected 1", ndone); else passes++;
    endtask

    task automatic test_skew;
        int c0;
        issue_cmd(2, 1'b0, c0);
        send_beat(1, 1, 1, 1, 1);
        @(negedge clk);
        @(negedge clk);
        send_beat(2, 10, 20, 30, 40);
        drain(0);
        for (int i = 0; i < N; i++) begin
            exp_v = AW'(20 * (i + 1) + 1);
            checks++;
            if (res[i] !== exp_v) $display("FAIL skew res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
    endtask

    task automatic test_backpressure;
        int c0;
        int w = 0;
        issue_cmd(1, 1'b0, c0);
        send_beat(3, 1, 2, 3, 4);
        bus.out_ready = 1'b1;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.out_data !== AW'(3)) $display("FAIL bp res[0]: got %0d expected 3 (valid %b)", $signed(bus.out_data), bus.out_valid);
        else passes++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, AW'(6)})
                $display("FAIL bp hold cycle %0d: got valid %b data %0d expected valid 1 data 6", k, bus.out_valid, $signed(bus.out_data));
            else passes++;
            bus.cmd_valid = (k == 2);
            bus.cmd_len   = LW'(3);
            bus.cmd_acc   = 1'b0;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        drain(1);
        for (int i = 1; i < N; i++) begin
            exp_v = AW'(3 * (i + 1));
            checks++;
            if (res[i] !== exp_v) $display("FAIL bp res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
        checks++; if (ndone != 1) $display("FAIL bp done pulses: got %0d expected 1", ndone); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL bp ignored cmd busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp ignored cmd in_ready: got %b expected 0", bus.in_ready); else passes++;
    endtask

    task automatic test_wrap;
        int c0;
        issue_cmd(40, 1'b0, c0);
        for (int j = 0; j < 40; j++) send_beat(-128, -128, -128, -128, -128);
        drain(0);
`ifdef SYSTOLIC_MAC_SAT_EN
        exp_v = AW'(524287);
`else
        exp_v = AW'(-393216);
`endif
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res[i] !== exp_v) $display("FAIL wrap res[%0d]: got %0d expected %0d", i, $signed(res[i]), $signed(exp_v));
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        int dcount = 0;
        issue_cmd(5, 1'b0, c0);
        send_beat(1, 1, 1, 1, 1);
        send_beat(2, 2, 2, 2, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL midreset in_ready: got %b expected 0", bus.in_ready); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL midreset busy: got %b expected 0", bus.busy); else passes++;
        for (int k = 0; k < 3; k++) begin
            if (bus.done) dcount++;
            @(negedge clk);
        end
        checks++; if (dcount != 0) $display("FAIL midreset done pulses: got %0d expected 0", dcount); else passes++;
        issue_cmd(0, 1'b1, c0);
        drain(0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res[i] !== '0) $display("FAIL midreset res[%0d]: got %0d expected 0", i, $signed(res[i]));
            else passes++;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_acc   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_data    = '0;
        bus.b_data    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_accumulate();
        test_skew();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
